// File: rtl/goose_vga_timing.sv
// Video timing generator for 640x480@60 Hz: beam position, registered syncs and line/frame strobes.
// Define VGA_FRAME_CNT_EN to add the frame_cnt completed-frame counter output.
module goose_vga_timing #(
  parameter int H_VISIBLE   = 640,
  parameter int H_FRONT     = 16,
  parameter int H_SYNC      = 96,
  parameter int H_BACK      = 48,
  parameter int V_VISIBLE   = 480,
  parameter int V_FRONT     = 10,
  parameter int V_SYNC      = 2,
  parameter int V_BACK      = 33,
  parameter bit SYNC_ACTIVE = 1'b0,
  parameter int FRAME_W     = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               pix_en,
  output logic [9:0]         hpos,
  output logic [9:0]         vpos,
  output logic               hsync,
  output logic               vsync,
  output logic               display_on,
  output logic               line_end,
  output logic               frame_end
`ifdef VGA_FRAME_CNT_EN
  ,
  output logic [FRAME_W-1:0] frame_cnt
`endif
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS_END  = 10'(H_VISIBLE);
  localparam logic [9:0] V_VIS_END  = 10'(V_VISIBLE);
  localparam logic [9:0] HS_START   = 10'(H_VISIBLE + H_FRONT);
  localparam logic [9:0] HS_END     = 10'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [9:0] VS_START   = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0] VS_END     = 10'(V_VISIBLE + V_FRONT + V_SYNC);
  localparam logic       SYNC_IDLE  = ~SYNC_ACTIVE;

  // Elaboration guards: the 10-bit position outputs must hold the last column/line.
  generate
    if (H_TOTAL - 1 > 1023) begin : g_h_total_chk
      $error("goose_vga_timing: H_TOTAL-1 exceeds 1023");
    end
    if (V_TOTAL - 1 > 1023) begin : g_v_total_chk
      $error("goose_vga_timing: V_TOTAL-1 exceeds 1023");
    end
    if (FRAME_W < 1) begin : g_frame_w_chk
      $error("goose_vga_timing: FRAME_W must be at least 1");
    end
  endgenerate

  logic [9:0] h_reg, h_next;
  logic [9:0] v_reg, v_next;
  logic       hsync_reg, hsync_next;
  logic       vsync_reg, vsync_next;
  logic       h_wrap;
  logic       v_wrap;

  assign h_wrap = (h_reg == H_LAST);
  assign v_wrap = (v_reg == V_LAST);

  always_comb begin
    h_next = h_reg;
    v_next = v_reg;
    if (pix_en) begin
      if (h_wrap) begin
        h_next = '0;
        v_next = v_wrap ? '0 : v_reg + 10'd1;
      end else begin
        h_next = h_reg + 10'd1;
      end
    end
  end

  // Syncs are decoded from the upcoming position so the registered level lines up with hpos/vpos.
  always_comb begin
    hsync_next = SYNC_IDLE;
    vsync_next = SYNC_IDLE;
    if (h_next >= HS_START && h_next < HS_END) begin
      hsync_next = SYNC_ACTIVE;
    end
    if (v_next >= VS_START && v_next < VS_END) begin
      vsync_next = SYNC_ACTIVE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      h_reg     <= '0;
      v_reg     <= '0;
      hsync_reg <= SYNC_IDLE;
      vsync_reg <= SYNC_IDLE;
    end else begin
      h_reg     <= h_next;
      v_reg     <= v_next;
      hsync_reg <= hsync_next;
      vsync_reg <= vsync_next;
    end
  end

`ifdef VGA_FRAME_CNT_EN
  logic [FRAME_W-1:0] frame_cnt_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      frame_cnt_reg <= '0;
    end else if (pix_en && h_wrap && v_wrap) begin
      frame_cnt_reg <= frame_cnt_reg + 1'b1;
    end
  end

  assign frame_cnt = frame_cnt_reg;
`endif

  assign hpos       = h_reg;
  assign vpos       = v_reg;
  assign hsync      = hsync_reg;
  assign vsync      = vsync_reg;
  assign display_on = (h_reg < H_VIS_END) && (v_reg < V_VIS_END);
  assign line_end   = h_wrap;
  assign frame_end  = h_wrap && v_wrap;

endmodule
